maquina_maluca_seq: RTL and testbench
=====================================

MAQUINA_MALUCA_SEQ -- requirements
Module: maquina_maluca_seq

Interface
REQ-001 SHALL have parameter DWELL, default 4: cycles each timed state is held (legal range 1..255).
REQ-002 SHALL have parameter MAX_FILL, default 3: refill attempts allowed before fault (legal range 1..15).
REQ-003 SHALL have parameter CNT_W, default 8: width of batch_cnt.
REQ-004 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port start, input, 1 bit: request one brew cycle.
REQ-007 SHALL have port agua_ok, input, 1 bit: water level sufficient.
REQ-008 SHALL have port hold, input, 1 bit: freeze the dwell timer.
REQ-009 SHALL have port abort, input, 1 bit: cancel the current cycle (see REQ-025).
REQ-010 SHALL have port state, output, 4 bits: current state encoding (registered).
REQ-011 SHALL have port busy, output, 1 bit: high whenever state is not IDLE and not FAULT.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse on cycle completion.
REQ-013 SHALL have port batch_cnt, output, CNT_W bits: completed-cycle count.

Function
REQ-014 SHALL use this state encoding: IDLE=0, LIGAR=1, CHECK=2, ENCHER=3, MOER=4, FILTRO=5, EXTRAIR=6, FAULT=7; codes 8..15 are unreachable and SHALL return to IDLE on the next edge.
REQ-015 SHALL move IDLE->LIGAR on the edge where start=1; start in any other state SHALL be ignored.
REQ-016 SHALL treat LIGAR, ENCHER, MOER, FILTRO and EXTRAIR as timed states: the dwell counter is cleared on entry, increments each cycle with hold=0, and the state exits on the edge where counter==DWELL-1 and hold=0; each timed state therefore lasts exactly DWELL cycles absent hold.
REQ-017 SHALL freeze both the dwell counter and the state while hold=1; hold SHALL have no effect in IDLE, CHECK or FAULT.
REQ-018 SHALL follow the timed-state exits LIGAR->CHECK, ENCHER->CHECK, MOER->FILTRO, FILTRO->EXTRAIR and EXTRAIR->IDLE.
REQ-019 SHALL hold CHECK for exactly one cycle: agua_ok=1 -> MOER; agua_ok=0 with fill_cnt<MAX_FILL -> ENCHER (fill_cnt+1); agua_ok=0 with fill_cnt==MAX_FILL -> FAULT.
REQ-020 SHALL clear fill_cnt in IDLE.
REQ-021 SHALL keep FAULT until rst (or abort, per REQ-025).
REQ-022 SHALL assert done for exactly the first cycle in which state shows IDLE after EXTRAIR; no other path SHALL raise done.
REQ-023 SHALL increment batch_cnt by 1 together with done, saturating at 2^CNT_W-1 (no wrap).

Reset
REQ-024 SHALL drive, on any clk edge with rst=1 regardless of current state or other inputs: state=IDLE, busy=0, done=0, batch_cnt=0, dwell counter=0, fill_cnt=0; rst SHALL have priority over abort, hold and start.

Configuration
REQ-025 SHALL honour macro MAQUINA_ABORT_EN: when defined, abort=1 in any state other than IDLE forces state=IDLE on the next edge, with no done pulse, batch_cnt unchanged and counters cleared, taking priority over hold; when undefined, the abort port SHALL exist but be ignored.

Verification (DWELL=3, MAX_FILL=2, CNT_W=8, macro defined unless noted)
REQ-026 SHALL cover: rst=1 for 2 cycles with start=1 -> state=0, busy=0, done=0, batch_cnt=0.
REQ-027 SHALL cover: 1-cycle start pulse, agua_ok=1 -> state sequence 1,1,1,2,4,4,4,5,5,5,6,6,6,0; done=1 only in that first 0 cycle; batch_cnt=1.
REQ-028 SHALL cover: start, agua_ok=0 held -> sequence 1,1,1,2,3,3,3,2,3,3,3,2,7, then 7 held; busy=0 in FAULT.
REQ-029 SHALL cover: hold=1 for 5 cycles starting at the 2nd MOER cycle -> MOER lasts 8 cycles total, then FILTRO lasts 3.
REQ-030 SHALL cover: abort=1 during the 2nd FILTRO cycle -> state=0 next cycle, done=0, batch_cnt unchanged; repeated with macro undefined -> cycle completes normally and batch_cnt increments.
REQ-031 SHALL cover: rst=1 during EXTRAIR -> state=0 next cycle, no done, batch_cnt=0.

Source files
------------

// File: rtl/maquina_maluca_seq.sv
// ============================================================================
// Module      : maquina_maluca_seq
// Description : Brew-cycle sequencer ("maquina maluca"). A start request walks
//               the machine through heat-up (LIGAR), a water check (CHECK),
//               optional refills (ENCHER), grind (MOER), filter (FILTRO) and
//               extraction (EXTRAIR). Timed states last DWELL cycles and can
//               be frozen with hold. Running out of refill attempts parks the
//               machine in FAULT until reset.
//
// Parameters  : DWELL    - cycles each timed state is held (1..255)
//               MAX_FILL - refill attempts allowed before FAULT (1..15)
//               CNT_W    - width of batch_cnt
//
// Ports       : clk       - clock, all updates on rising edge
//               rst       - synchronous active-high reset (top priority)
//               start     - request one brew cycle (honoured in IDLE only)
//               agua_ok   - water level sufficient
//               hold      - freeze the dwell timer in timed states
//               abort     - cancel current cycle (only with MAQUINA_ABORT_EN)
//               state     - registered state code
//               busy      - state is neither IDLE nor FAULT
//               done      - one-cycle pulse on the first IDLE after EXTRAIR
//               batch_cnt - saturating count of completed cycles
//
// Build macro : MAQUINA_ABORT_EN - when defined, abort returns any non-IDLE
//               state to IDLE; when undefined, abort is ignored.
//
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module maquina_maluca_seq #(
    parameter int DWELL    = 4,
    parameter int MAX_FILL = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             agua_ok,
    input  logic             hold,
    input  logic             abort,
    output logic [3:0]       state,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] batch_cnt
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LIGAR   = 4'd1,
        S_CHECK   = 4'd2,
        S_ENCHER  = 4'd3,
        S_MOER    = 4'd4,
        S_FILTRO  = 4'd5,
        S_EXTRAIR = 4'd6,
        S_FAULT   = 4'd7
    } state_t;

    // Last dwell count of a timed state; the exit happens on this value.
    localparam logic [7:0]       c_dwell_last = 8'(DWELL - 1);
    localparam logic [3:0]       c_max_fill   = 4'(MAX_FILL);
    localparam logic [CNT_W-1:0] c_batch_max  = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_dwell;
    logic [7:0]       w_dwell_nxt;
    logic [3:0]       r_fill;
    logic [3:0]       w_fill_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic [CNT_W-1:0] r_batch;
    logic             w_abort;

`ifdef MAQUINA_ABORT_EN
    assign w_abort = abort && (r_state != S_IDLE);
`else
    // Port kept for pin compatibility; it has no function in this build.
    logic w_unused_abort;
    assign w_unused_abort = abort;
    assign w_abort        = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state / counter logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_dwell_nxt = r_dwell;
        w_fill_nxt  = r_fill;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_dwell_nxt = '0;
                w_fill_nxt  = '0;
                if (start) begin
                    w_state_nxt = S_LIGAR;
                end
            end

            S_LIGAR, S_ENCHER, S_MOER, S_FILTRO, S_EXTRAIR: begin
                // hold freezes both the counter and the state.
                if (!hold) begin
                    if (r_dwell == c_dwell_last) begin
                        // Counter restarts at zero for whichever timed state
                        // comes next.
                        w_dwell_nxt = '0;
                        case (r_state)
                            S_LIGAR, S_ENCHER: w_state_nxt = S_CHECK;
                            S_MOER:            w_state_nxt = S_FILTRO;
                            S_FILTRO:          w_state_nxt = S_EXTRAIR;
                            default: begin
                                // EXTRAIR completes the brew.
                                w_state_nxt = S_IDLE;
                                w_done_nxt  = 1'b1;
                            end
                        endcase
                    end else begin
                        w_dwell_nxt = r_dwell + 8'd1;
                    end
                end
            end

            S_CHECK: begin
                w_dwell_nxt = '0;
                if (agua_ok) begin
                    w_state_nxt = S_MOER;
                end else if (r_fill < c_max_fill) begin
                    w_state_nxt = S_ENCHER;
                    w_fill_nxt  = r_fill + 4'd1;
                end else begin
                    w_state_nxt = S_FAULT;
                end
            end

            S_FAULT: begin
                w_dwell_nxt = '0;
            end

            default: begin
                // Codes 8..15 cannot be reached normally; recover to IDLE.
                w_state_nxt = S_IDLE;
                w_dwell_nxt = '0;
                w_fill_nxt  = '0;
            end
        endcase

        // Abort overrides everything above, including hold, and never
        // produces a done pulse.
        if (w_abort) begin
            w_state_nxt = S_IDLE;
            w_dwell_nxt = '0;
            w_fill_nxt  = '0;
            w_done_nxt  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_dwell <= '0;
            r_fill  <= '0;
            r_done  <= 1'b0;
            r_batch <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dwell <= w_dwell_nxt;
            r_fill  <= w_fill_nxt;
            r_done  <= w_done_nxt;
            // Count saturates rather than wrapping.
            if (w_done_nxt && (r_batch != c_batch_max)) begin
                r_batch <= r_batch + 1'b1;
            end
        end
    end

    assign state     = r_state;
    assign busy      = (r_state != S_IDLE) && (r_state != S_FAULT);
    assign done      = r_done;
    assign batch_cnt = r_batch;

endmodule

`default_nettype wire

// File: tb/tb_maquina_maluca_seq.sv
// ============================================================================
// Module      : tb_maquina_maluca_seq
// Description : Self-checking bench for maquina_maluca_seq (DWELL=3,
//               MAX_FILL=2, CNT_W=8). A phase/remaining-time reference model
//               predicts state, busy, done and batch_cnt every cycle; directed
//               scenarios add explicit sequence checks, followed by random
//               traffic and a batch-count saturation run.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_maquina_maluca_seq;

    localparam int DWELL    = 3;
    localparam int MAX_FILL = 2;
    localparam int CNT_W    = 8;
    localparam int BATCH_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             agua_ok;
    logic             hold;
    logic             abort;
    logic [3:0]       state;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] batch_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: phase plus cycles remaining in the current phase.
    int m_phase;
    int m_left;
    int m_fills;
    int m_batch;
    int m_done;

    maquina_maluca_seq #(
        .DWELL    (DWELL),
        .MAX_FILL (MAX_FILL),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .agua_ok   (agua_ok),
        .hold      (hold),
        .abort     (abort),
        .state     (state),
        .busy      (busy),
        .done      (done),
        .batch_cnt (batch_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_enter(input int ph);
        m_phase = ph;
        m_left  = DWELL;
    endfunction

    function automatic void model_step(input bit r, input bit s, input bit a,
                                       input bit h, input bit ab);
        m_done = 0;
        if (r) begin
            m_phase = 0; m_left = 0; m_fills = 0; m_batch = 0;
            return;
        end
`ifdef MAQUINA_ABORT_EN
        if (ab && m_phase != 0) begin
            m_phase = 0; m_fills = 0;
            return;
        end
`endif
        case (m_phase)
            0: begin
                m_fills = 0;
                if (s) model_enter(1);
            end
            2: begin
                if (a) model_enter(4);
                else if (m_fills < MAX_FILL) begin
                    m_fills++;
                    model_enter(3);
                end else m_phase = 7;
            end
            7: ;
            default: begin
                if (!h) begin
                    m_left--;
                    if (m_left == 0) begin
                        case (m_phase)
                            1, 3: m_phase = 2;
                            4: model_enter(5);
                            5: model_enter(6);
                            default: begin
                                m_phase = 0;
                                m_done  = 1;
                                if (m_batch < BATCH_MAX) m_batch++;
                            end
                        endcase
                    end
                end
            end
        endcase
    endfunction

    // One clock: inputs are already set; sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        model_step(rst, start, agua_ok, hold, abort);
        check_eq("state", int'(state), m_phase);
        check_eq("busy", int'(busy), (m_phase != 0 && m_phase != 7) ? 1 : 0);
        check_eq("done", int'(done), m_done);
        check_eq("batch_cnt", int'(batch_cnt), m_batch);
    endtask

    task automatic wait_state(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (int'(state) == target) break;
            tick();
        end
        check_eq("wait_state", int'(state), target);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b1;
        tick(); tick();
        rst = 1'b0; start = 1'b0;
    endtask

    initial begin : main
        int seq_ok[14];
        int seq_fault[15];
        int n_moer, n_filtro, n_filtro_seen, b0;

        seq_ok    = '{1,1,1,2,4,4,4,5,5,5,6,6,6,0};
        seq_fault = '{1,1,1,2,3,3,3,2,3,3,3,2,7,7,7};

        rst = 1'b1; start = 1'b0; agua_ok = 1'b0; hold = 1'b0; abort = 1'b0;
        m_phase = 0; m_left = 0; m_fills = 0; m_batch = 0; m_done = 0;

        // Reset with start asserted
        do_reset();
        check_eq("rst_state", int'(state), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_batch", int'(batch_cnt), 0);

        // Normal brew
        agua_ok = 1'b1;
        for (int i = 0; i < 14; i++) begin
            start = (i == 0);
            tick();
            check_eq("seq_ok", int'(state), seq_ok[i]);
            check_eq("seq_ok_done", int'(done), (i == 13) ? 1 : 0);
        end
        check_eq("seq_ok_batch", int'(batch_cnt), 1);
        start = 1'b0;
        tick();
        check_eq("done_one_cycle", int'(done), 0);

        // Dry tank: refills exhausted -> FAULT
        agua_ok = 1'b0;
        for (int i = 0; i < 15; i++) begin
            start = (i == 0);
            tick();
            check_eq("seq_fault", int'(state), seq_fault[i]);
        end
        check_eq("fault_busy", int'(busy), 0);
        start = 1'b1;
        tick();
        check_eq("fault_ignores_start", int'(state), 7);
        start = 1'b0;
        do_reset();

        // Hold during MOER
        agua_ok = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        n_moer = 0; n_filtro = 0;
        for (int i = 0; i < 40; i++) begin
            if (int'(state) == 4) n_moer++;
            if (int'(state) == 5) n_filtro++;
            if (int'(state) == 6) break;
            hold = (int'(state) == 4 && n_moer >= 2 && n_moer <= 6);
            tick();
        end
        hold = 1'b0;
        check_eq("moer_len", n_moer, 8);
        check_eq("filtro_len", n_filtro, 3);
        wait_state(0, 10);

        // Abort in the 2nd FILTRO cycle
        b0 = int'(batch_cnt);
        start = 1'b1; tick(); start = 1'b0;
        wait_state(5, 20);
        tick();
        check_eq("abort_at_filtro2", int'(state), 5);
        abort = 1'b1; tick(); abort = 1'b0;
`ifdef MAQUINA_ABORT_EN
        check_eq("abort_state", int'(state), 0);
        check_eq("abort_done", int'(done), 0);
        check_eq("abort_batch", int'(batch_cnt), b0);
`else
        check_eq("noabort_state", int'(state), 5);
        wait_state(0, 20);
        check_eq("noabort_done", int'(done), 1);
        check_eq("noabort_batch", int'(batch_cnt), b0 + 1);
`endif

        // Reset during EXTRAIR
        tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_state(6, 30);
        rst = 1'b1; tick(); rst = 1'b0;
        check_eq("rst_extrair_state", int'(state), 0);
        check_eq("rst_extrair_done", int'(done), 0);
        check_eq("rst_extrair_batch", int'(batch_cnt), 0);
        tick();
        check_eq("rst_extrair_nodone", int'(done), 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 63) == 0);
            start   = ($urandom_range(0, 3) == 0);
            agua_ok = ($urandom_range(0, 3) != 0);
            hold    = ($urandom_range(0, 7) == 0);
            abort   = ($urandom_range(0, 31) == 0);
            tick();
        end
        rst = 1'b0; start = 1'b0; hold = 1'b0; abort = 1'b0;

        // Saturation of batch_cnt
        do_reset();
        agua_ok = 1'b1;
        start   = 1'b1;
        for (int i = 0; i < 260 * (5 * DWELL + 2); i++) tick();
        start = 1'b0;
        wait_state(0, 30);
        check_eq("batch_saturated", int'(batch_cnt), BATCH_MAX);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
